rib_mem_slave: RTL and testbench
================================

RIB_MEM_SLAVE -- requirements
Module: rib_mem_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning memory size in 32-bit words; it SHALL be a power of two, range 2..65536.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning added wait states per access; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_i, input, 1 bit: access request from the bus master.
REQ-006 SHALL have port we_i, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port addr_i, input, 32 bits: byte address; word index = addr_i[log2(DEPTH)+1:2].
REQ-008 SHALL have port data_i, input, 32 bits: write data.
REQ-009 SHALL have port data_o, output, 32 bits: read data.
REQ-010 SHALL have port hold_o, output, 1 bit: stall request to the bus/ctrl hold path.
REQ-011 SHALL have port ack_o, output, 1 bit: access-complete pulse.
REQ-012 SHALL have port err_o, output, 1 bit: out-of-range pulse, asserted together with ack_o.

Function
REQ-013 SHALL implement states IDLE, WAIT, RESP.
REQ-014 IDLE with req_i=1: SHALL capture addr_i, we_i, data_i; load cnt=WAIT_CYCLES-1; go to WAIT.
REQ-015 IDLE with req_i=0: SHALL stay in IDLE; inputs ignored.
REQ-016 hold_o SHALL be combinational: 1 when (IDLE and req_i) or WAIT, else 0.
REQ-017 Consequence of REQ-014 and REQ-016: hold_o is high for exactly WAIT_CYCLES+1 consecutive cycles per access.
REQ-018 WAIT with cnt!=0: SHALL decrement cnt and stay in WAIT.
REQ-019 WAIT with cnt==0: SHALL go to RESP, using the captured address for both actions on that same edge:
- write: commit captured data to memory.
- read: register the memory word into data_o.
REQ-020 WAIT SHALL ignore req_i, we_i, addr_i and data_i; a request dropped mid-WAIT still completes, including a write commit.
REQ-021 RESP SHALL last exactly one cycle, then go to IDLE, with:
- ack_o=1;
- hold_o=0;
- data_o = read data for reads, 0 for writes.
REQ-022 The master SHALL sample data_o during the RESP cycle.
REQ-023 data_o SHALL be 0 in IDLE and WAIT.
REQ-024 A req_i seen in the cycle after RESP SHALL start a new access; back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
REQ-025 Out-of-range access is any address with bits above log2(DEPTH)+1 nonzero; timing SHALL be identical to a normal access, and:
- a write SHALL be dropped;
- a read SHALL return 0;
- err_o SHALL be 1 in RESP.
REQ-026 addr_i[1:0] SHALL be ignored (word access only).
REQ-027 Memory contents SHALL not be initialised by reset; reads of never-written words are unspecified.

Reset
REQ-028 On rst=1 at a clock edge, the following SHALL hold:
- state=IDLE, cnt=0, captured registers=0;
- data_o=0, ack_o=0, err_o=0;
- hold_o SHALL follow REQ-016 (0 unless req_i).
REQ-029 Reset during WAIT SHALL abort the access with no memory write and no ack_o pulse.
REQ-030 Reset SHALL not alter memory contents.

Verification
REQ-031 Write then read, WAIT_CYCLES=2: write 0xDEADBEEF to addr 0x10, then read addr 0x10 -> hold_o high 3 cycles each access; RESP of the read gives data_o=0xDEADBEEF, ack_o=1, err_o=0.
REQ-032 Latency sweep: WAIT_CYCLES=1 and WAIT_CYCLES=15, single read -> hold_o high 2 and 16 cycles respectively, ack_o on the next cycle.
REQ-033 Out of range, DEPTH=1024: write 0x12345678 to 0x1000, then read 0x1000 and 0x0000 -> read of 0x1000 returns 0 with err_o=1; 0x0000 is unchanged.
REQ-034 Request dropped: req_i falls in the cycle after a write request to 0x20 with data 0xA5A5A5A5 -> ack_o still pulses; a later read of 0x20 returns 0xA5A5A5A5.
REQ-035 Reset mid-WAIT: write 0x55 to 0x30, assert rst during WAIT -> no ack_o, next-cycle state IDLE with hold_o=0 (req_i low); 0x30 retains its prior value.
REQ-036 Back-to-back: req_i held high across 3 reads of 0x0, 0x4, 0x8 -> 3 ack_o pulses spaced WAIT_CYCLES+2 cycles apart, each with the correct data.

Source files
------------

// File: rtl/rib_mem_slave.sv
// rtl/rib_mem_slave.sv - word-addressed RIB memory slave with fixed wait states
// Access runs IDLE -> WAIT (WAIT_CYCLES cycles) -> RESP; out-of-range addresses complete with err_o.
module rib_mem_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        hold_o,
  output logic        ack_o,
  output logic        err_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:2] r_addr;
  logic [31:0] r_data;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH];

  logic          w_oor;
  logic [AW-1:0] w_idx;
  logic          w_done;

  assign w_oor  = |r_addr[31:AW+2];
  assign w_idx  = r_addr[AW+1:2];
  assign w_done = (r_state == S_WAIT) && (r_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && req_i) begin
        r_we   <= we_i;
        r_addr <= addr_i[31:2];
        r_data <= data_i;
        r_cnt  <= 4'(WAIT_CYCLES - 1);
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Read data lives only for the RESP cycle; every other cycle it reloads as zero.
      if (w_done && !r_we && !w_oor) r_rdata <= r_mem[w_idx];
      else                           r_rdata <= 32'd0;
    end
  end

  // Memory has no reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && w_done && r_we && !w_oor) r_mem[w_idx] <= r_data;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_i) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    hold_o = ((r_state == S_IDLE) && req_i) || (r_state == S_WAIT);
    ack_o  = (r_state == S_RESP);
    err_o  = (r_state == S_RESP) && w_oor;
    data_o = r_rdata;
  end
endmodule

// File: tb/tb_rib_mem_slave.sv
// tb/tb_rib_mem_slave.sv - directed scoreboard bench for rib_mem_slave
// Main instance uses WAIT_CYCLES=2; two small instances cover the latency extremes.
module tb_rib_mem_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_m = 1'b0;
  logic        req_s = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;

  logic [31:0] data_m, data_1, data_15;
  logic        hold_m, ack_m, err_m;
  logic        hold_1, ack_1, err_1;
  logic        hold_15, ack_15, err_15;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ack_cyc = 0;

  typedef struct { logic [31:0] d; logic e; } exp_t;
  exp_t sb[$];

  rib_mem_slave #(.DEPTH(1024), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .req_i(req_m), .we_i(we), .addr_i(addr), .data_i(wdata),
    .data_o(data_m), .hold_o(hold_m), .ack_o(ack_m), .err_o(err_m));

  rib_mem_slave #(.DEPTH(16), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .req_i(req_s), .we_i(we), .addr_i(addr), .data_i(wdata),
    .data_o(data_1), .hold_o(hold_1), .ack_o(ack_1), .err_o(err_1));

  rib_mem_slave #(.DEPTH(16), .WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .rst(rst), .req_i(req_s), .we_i(we), .addr_i(addr), .data_i(wdata),
    .data_o(data_15), .hold_o(hold_15), .ack_o(ack_15), .err_o(err_15));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one access on the main instance; keep=1 leaves req_m high afterwards.
  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] ed, input logic ee,
                        input logic keep);
    exp_t e;
    int   hc = 0;
    int   n  = 0;
    bit   got = 0;
    sb.push_back('{ed, ee});
    @(posedge clk); #1;
    req_m = 1'b1; we = w; addr = a; wdata = d;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (ack_m) begin
        got = 1;
        ack_cyc = cyc;
        e = sb.pop_front();
        check({tag, " data"}, data_m, e.d);
        check({tag, " err"}, 32'(err_m), 32'(e.e));
        check({tag, " hold_in_resp"}, 32'(hold_m), 32'd0);
      end else begin
        if (hold_m) hc++;
        n++;
        @(posedge clk); #1;
        if (!keep) req_m = 1'b0;
      end
    end
    check({tag, " ack_seen"}, 32'(got), 32'd1);
    check({tag, " hold_cycles"}, 32'(hc), 32'd3);
    check({tag, " ack_latency"}, 32'(n), 32'd3);
  endtask

  initial begin
    int h1, h15, a1, a15, bad_data, acks, prev;

    // Reset: outputs quiet, hold follows req_i
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst data_o", data_m, 32'd0);
    check("rst ack_o", 32'(ack_m), 32'd0);
    check("rst err_o", 32'(err_m), 32'd0);
    check("rst hold_o idle", 32'(hold_m), 32'd0);
    req_m = 1'b1;
    #1;
    check("rst hold_o follows req", 32'(hold_m), 32'd1);
    @(posedge clk); #1;
    check("rst holds IDLE", 32'(hold_m), 32'd1);
    req_m = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post-rst hold_o", 32'(hold_m), 32'd0);

    // Write then read
    access("wr 0x10", 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
    access("rd 0x10", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 1'b0);
    access("rd 0x13 lowbits", 1'b0, 32'h13, 32'd0, 32'hDEADBEEF, 1'b0, 1'b0);
    access("wr top", 1'b1, 32'hFFC, 32'h0BADF00D, 32'd0, 1'b0, 1'b0);
    access("rd top", 1'b0, 32'hFFC, 32'd0, 32'h0BADF00D, 1'b0, 1'b0);

    // Out of range must not alias onto word 0
    access("wr 0x0", 1'b1, 32'h0, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0);
    access("wr oor", 1'b1, 32'h1000, 32'h12345678, 32'd0, 1'b1, 1'b0);
    access("rd oor", 1'b0, 32'h1000, 32'd0, 32'd0, 1'b1, 1'b0);
    access("rd 0x0 after oor", 1'b0, 32'h0, 32'd0, 32'hCAFEF00D, 1'b0, 1'b0);
    access("rd oor high", 1'b0, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b0);

    // Request dropped after capture still commits
    access("wr 0x20 dropped", 1'b1, 32'h20, 32'hA5A5A5A5, 32'd0, 1'b0, 1'b0);
    access("rd 0x20", 1'b0, 32'h20, 32'd0, 32'hA5A5A5A5, 1'b0, 1'b0);

    // Reset on the commit edge aborts the write
    access("wr 0x30 prior", 1'b1, 32'h30, 32'h11111111, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    req_m = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h55;
    @(posedge clk); #1;
    req_m = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstwait hold_o", 32'(hold_m), 32'd0);
    check("rstwait data_o", data_m, 32'd0);
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      if (ack_m) acks++;
      @(negedge clk);
    end
    check("rstwait no ack", 32'(acks), 32'd0);
    access("rd 0x30 retained", 1'b0, 32'h30, 32'd0, 32'h11111111, 1'b0, 1'b0);

    // Back-to-back reads with req held high
    access("wr 0x4", 1'b1, 32'h4, 32'h04040404, 32'd0, 1'b0, 1'b0);
    access("wr 0x8", 1'b1, 32'h8, 32'h08080808, 32'd0, 1'b0, 1'b0);
    access("b2b rd 0x0", 1'b0, 32'h0, 32'd0, 32'hCAFEF00D, 1'b0, 1'b1);
    prev = ack_cyc;
    access("b2b rd 0x4", 1'b0, 32'h4, 32'd0, 32'h04040404, 1'b0, 1'b1);
    check("b2b spacing 1", 32'(ack_cyc - prev), 32'd4);
    prev = ack_cyc;
    access("b2b rd 0x8", 1'b0, 32'h8, 32'd0, 32'h08080808, 1'b0, 1'b1);
    check("b2b spacing 2", 32'(ack_cyc - prev), 32'd4);
    @(posedge clk); #1;
    req_m = 1'b0;
    check("scoreboard empty", 32'(sb.size()), 32'd0);

    // Latency sweep on the WAIT_CYCLES=1 and 15 instances
    h1 = 0; h15 = 0; a1 = -1; a15 = -1; bad_data = 0;
    @(posedge clk); #1;
    req_s = 1'b1; we = 1'b0; addr = 32'h0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (hold_1) h1++;
      if (hold_15) h15++;
      if (ack_1 && a1 < 0) a1 = k;
      if (ack_15 && a15 < 0) a15 = k;
      if ((hold_1 && data_1 != 32'd0) || (hold_15 && data_15 != 32'd0)) bad_data++;
      if ((ack_1 && err_1) || (ack_15 && err_15)) bad_data++;
      @(posedge clk); #1;
      req_s = 1'b0;
    end
    check("w1 hold_cycles", 32'(h1), 32'd2);
    check("w1 ack_cycle", 32'(a1), 32'd2);
    check("w15 hold_cycles", 32'(h15), 32'd16);
    check("w15 ack_cycle", 32'(a15), 32'd16);
    check("sweep data/err quiet", 32'(bad_data), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
